// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-through, no-write-allocate data cache in front of one BRAM port.
// Refills whole lines on load misses; every store is forwarded to memory.
`ifndef DATAMEM_BITS
`define DATAMEM_BITS 11
`endif

module dcache_direct_mapped #(
    parameter int ADDR_WIDTH  = `DATAMEM_BITS - 1,
    parameter int INDEX_BITS  = 4,
    parameter int OFFSET_BITS = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cpu_req,
    input  logic [3:0]            i_cpu_we,
    input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
    input  logic [31:0]           i_cpu_wdata,
    output logic [31:0]           o_cpu_rdata,
    output logic                  o_cpu_ready,
    output logic                  o_mem_en,
    output logic [3:0]            o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [31:0]           o_mem_din,
    input  logic [31:0]           i_mem_dout
);

    localparam int TAG_W      = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
    localparam int LINES      = 2 ** INDEX_BITS;
    localparam int WORDS      = 2 ** (INDEX_BITS + OFFSET_BITS);
    localparam int LINE_WORDS = 2 ** OFFSET_BITS;
    localparam int CNT_W      = OFFSET_BITS + 1;
    localparam int WORD_BITS  = INDEX_BITS + OFFSET_BITS;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPARE = 2'd1;
    localparam logic [1:0] S_REFILL  = 2'd2;
    localparam logic [1:0] S_RESPOND = 2'd3;

    logic [1:0]             r_state;
    logic [LINES-1:0]       r_valid;
    logic [TAG_W-1:0]       r_tag [LINES];
    logic [ADDR_WIDTH-1:0]  r_req_addr;
    logic [3:0]             r_req_we;
    logic [31:0]            r_req_wdata;
    logic                   r_hit;
    logic [CNT_W-1:0]       r_issue_cnt;
    logic [OFFSET_BITS-1:0] r_capture_cnt;
    logic [31:0]            r_fill_word;
    logic [31:0]            r_cpu_rdata;
    logic                   r_cpu_ready;
    logic                   r_mem_en;
    logic [3:0]             r_mem_we;
    logic [ADDR_WIDTH-1:0]  r_mem_addr;
    logic [31:0]            r_mem_din;

    logic [INDEX_BITS-1:0]  w_in_idx;
    logic [TAG_W-1:0]       w_in_tag;
    logic [WORD_BITS-1:0]   w_in_word;
    logic                   w_in_hit;
    logic [31:0]            w_hit_word;
    logic [INDEX_BITS-1:0]  w_req_idx;
    logic [TAG_W-1:0]       w_req_tag;
    logic [OFFSET_BITS-1:0] w_req_off;
    logic [WORD_BITS-1:0]   w_req_word;
    logic [WORD_BITS-1:0]   w_cap_word;
    logic [OFFSET_BITS-1:0] w_next_off;
    logic                   w_capture;
    logic                   w_refill_last;
    logic                   w_store_hit;

    assign w_in_idx   = i_cpu_addr[OFFSET_BITS +: INDEX_BITS];
    assign w_in_tag   = i_cpu_addr[ADDR_WIDTH-1 -: TAG_W];
    assign w_in_word  = i_cpu_addr[WORD_BITS-1:0];
    assign w_in_hit   = r_valid[w_in_idx] && (r_tag[w_in_idx] == w_in_tag);

    assign w_req_idx  = r_req_addr[OFFSET_BITS +: INDEX_BITS];
    assign w_req_tag  = r_req_addr[ADDR_WIDTH-1 -: TAG_W];
    assign w_req_off  = r_req_addr[OFFSET_BITS-1:0];
    assign w_req_word = r_req_addr[WORD_BITS-1:0];
    assign w_cap_word = {w_req_idx, r_capture_cnt};
    assign w_next_off = r_issue_cnt[OFFSET_BITS-1:0] + OFFSET_BITS'(1);

    // REFILL cycle 0 only issues; cycles 1..LINE_WORDS each capture the previous read.
    assign w_capture     = (r_state == S_REFILL) && (r_issue_cnt != '0);
    assign w_refill_last = (r_state == S_REFILL) && (r_issue_cnt == CNT_W'(LINE_WORDS));
    assign w_store_hit   = (r_state == S_COMPARE) && r_hit && (r_req_we != 4'b0000);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_lane [WORDS];

            always_ff @(posedge i_clk) begin
                if (w_capture) begin
                    r_lane[w_cap_word] <= i_mem_dout[8*gi +: 8];
                end else if (w_store_hit && r_req_we[gi]) begin
                    r_lane[w_req_word] <= r_req_wdata[8*gi +: 8];
                end
            end

            assign w_hit_word[8*gi +: 8] = r_lane[w_in_word];
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (w_refill_last) begin
            r_tag[w_req_idx] <= w_req_tag;
        end
    end

    // Outputs are registered one edge ahead, so they are visible during the state they belong to.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_valid       <= '0;
            r_req_addr    <= '0;
            r_req_we      <= 4'b0000;
            r_req_wdata   <= '0;
            r_hit         <= 1'b0;
            r_issue_cnt   <= '0;
            r_capture_cnt <= '0;
            r_fill_word   <= '0;
            r_cpu_rdata   <= '0;
            r_cpu_ready   <= 1'b0;
            r_mem_en      <= 1'b0;
            r_mem_we      <= 4'b0000;
            r_mem_addr    <= '0;
            r_mem_din     <= '0;
        end else begin
            r_cpu_ready <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 4'b0000;
            case (r_state)
                S_IDLE: begin
                    if (i_cpu_req) begin
                        r_req_addr  <= i_cpu_addr;
                        r_req_we    <= i_cpu_we;
                        r_req_wdata <= i_cpu_wdata;
                        r_hit       <= w_in_hit;
                        r_state     <= S_COMPARE;
                        if (i_cpu_we != 4'b0000) begin
                            r_cpu_ready <= 1'b1;
                            r_mem_en    <= 1'b1;
                            r_mem_we    <= i_cpu_we;
                            r_mem_addr  <= i_cpu_addr;
                            r_mem_din   <= i_cpu_wdata;
                        end else if (w_in_hit) begin
                            r_cpu_ready <= 1'b1;
                            r_cpu_rdata <= w_hit_word;
                        end
                    end
                end
                S_COMPARE: begin
                    if ((r_req_we == 4'b0000) && !r_hit) begin
                        // Invalidate first so a partially refilled line can never hit.
                        r_valid[w_req_idx] <= 1'b0;
                        r_issue_cnt        <= '0;
                        r_capture_cnt      <= '0;
                        r_mem_en           <= 1'b1;
                        r_mem_addr         <= {w_req_tag, w_req_idx, {OFFSET_BITS{1'b0}}};
                        r_state            <= S_REFILL;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_REFILL: begin
                    r_issue_cnt <= r_issue_cnt + CNT_W'(1);
                    if (r_issue_cnt < CNT_W'(LINE_WORDS - 1)) begin
                        r_mem_en   <= 1'b1;
                        r_mem_addr <= {w_req_tag, w_req_idx, w_next_off};
                    end
                    if (w_capture) begin
                        r_capture_cnt <= r_capture_cnt + OFFSET_BITS'(1);
                        if (r_capture_cnt == w_req_off) begin
                            r_fill_word <= i_mem_dout;
                        end
                    end
                    if (w_refill_last) begin
                        r_valid[w_req_idx] <= 1'b1;
                        r_cpu_ready        <= 1'b1;
                        r_cpu_rdata        <= (r_capture_cnt == w_req_off) ? i_mem_dout : r_fill_word;
                        r_state            <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_cpu_rdata = r_cpu_rdata;
    assign o_cpu_ready = r_cpu_ready;
    assign o_mem_en    = r_mem_en;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_din   = r_mem_din;

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Bench for dcache_direct_mapped: BRAM model, directed vector table, reset-abort sequence,
// and random traffic checked against a line-level cache/memory reference model.
module tb_dcache_direct_mapped;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req;
    logic [3:0]    cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_wdata;
    logic [31:0]   cpu_rdata;
    logic          cpu_ready;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_din;
    logic [31:0]   mem_dout = 32'h0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] bram    [0:(1<<AW)-1];
    logic [31:0] ref_mem [0:(1<<AW)-1];
    bit          ref_valid [0:15];
    int          ref_tag   [0:15];

    typedef struct {
        logic [3:0]    we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        int            lat;
        logic [31:0]   rdata;
    } vec_t;

    vec_t vecs [8];

    dcache_direct_mapped #(.ADDR_WIDTH(AW), .INDEX_BITS(4), .OFFSET_BITS(2)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cpu_req   (cpu_req),
        .i_cpu_we    (cpu_we),
        .i_cpu_addr  (cpu_addr),
        .i_cpu_wdata (cpu_wdata),
        .o_cpu_rdata (cpu_rdata),
        .o_cpu_ready (cpu_ready),
        .o_mem_en    (mem_en),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_din   (mem_din),
        .i_mem_dout  (mem_dout)
    );

    always #5 clk = ~clk;

    // Byte-write BRAM, registered read with one cycle latency.
    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) bram[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
            end
            if (mem_we == 4'b0000) mem_dout <= bram[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, " rdata"},    cpu_rdata,       32'h0);
        chk({tag, " ready"},    32'(cpu_ready),  32'h0);
        chk({tag, " mem_en"},   32'(mem_en),     32'h0);
        chk({tag, " mem_we"},   32'(mem_we),     32'h0);
        chk({tag, " mem_addr"}, 32'(mem_addr),   32'h0);
        chk({tag, " mem_din"},  mem_din,         32'h0);
    endtask

    // Cache behaviour from first principles: loads return memory contents, misses fill a line.
    task automatic model_access(input logic [3:0] we, input logic [AW-1:0] a, input logic [31:0] wd,
                                output int lat, output logic [31:0] rd);
        int unsigned ai;
        int idx;
        int tg;
        ai  = 32'(a);
        idx = int'((ai / 4) % 16);
        tg  = int'(ai / 64);
        rd  = 32'h0;
        if (we != 4'b0000) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) ref_mem[ai][8*b +: 8] = wd[8*b +: 8];
            end
            lat = 1;
        end else begin
            if (ref_valid[idx] && ref_tag[idx] == tg) begin
                lat = 1;
            end else begin
                lat = 7;
                ref_valid[idx] = 1'b1;
                ref_tag[idx]   = tg;
            end
            rd = ref_mem[ai];
        end
    endtask

    task automatic run_txn(input string tag, input logic [3:0] we, input logic [AW-1:0] a,
                           input logic [31:0] wd, input int exp_lat, input logic [31:0] exp_rd);
        int lat = 0;
        int nreads = 0;
        int nwrites = 0;
        logic [31:0] rd;
        logic [31:0] base;
        base = {22'h0, a[AW-1:2], 2'b00};
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = wd;
        while (1) begin
            @(posedge clk);
            #1;
            lat++;
            if (mem_en) begin
                if (mem_we == 4'b0000) begin
                    chk({tag, " read addr"}, 32'(mem_addr), base + 32'(nreads));
                    nreads++;
                end else begin
                    chk({tag, " write addr"}, 32'(mem_addr), 32'(a));
                    chk({tag, " write we"},   32'(mem_we),   32'(we));
                    chk({tag, " write din"},  mem_din,       wd);
                    nwrites++;
                end
            end
            if (cpu_ready) break;
            if (lat >= 20) begin
                chk({tag, " ready timeout"}, 32'(lat), 32'(exp_lat));
                break;
            end
        end
        rd      = cpu_rdata;
        cpu_req = 1'b0;
        cpu_we  = 4'b0000;
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        if (we == 4'b0000) chk({tag, " rdata"}, rd, exp_rd);
        chk({tag, " mem reads"},  32'(nreads),  (we == 4'b0000 && exp_lat > 1) ? 32'd4 : 32'd0);
        chk({tag, " mem writes"}, 32'(nwrites), (we != 4'b0000) ? 32'd1 : 32'd0);
        @(posedge clk);
        #1;
        chk({tag, " ready pulse"}, 32'(cpu_ready), 32'h0);
        chk({tag, " rdata hold"},  cpu_rdata,      rd);
        $display("txn %s we=%b addr=%h wdata=%h lat=%0d rdata=%h", tag, we, a, wd, lat, rd);
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic [3:0]  we;
        logic [AW-1:0] a;
        logic [31:0] wd;

        for (int i = 0; i < (1<<AW); i++) begin
            bram[i]    = 32'hA000_0000 + 32'(i);
            ref_mem[i] = 32'hA000_0000 + 32'(i);
        end
        for (int i = 0; i < 16; i++) begin
            ref_valid[i] = 1'b0;
            ref_tag[i]   = 0;
        end

        vecs[0] = '{4'b0000, 10'h005, 32'h0,         7, 32'hA000_0005};
        vecs[1] = '{4'b0000, 10'h006, 32'h0,         1, 32'hA000_0006};
        vecs[2] = '{4'b0011, 10'h006, 32'h1234_5678, 1, 32'h0};
        vecs[3] = '{4'b0000, 10'h006, 32'h0,         1, 32'hA000_5678};
        vecs[4] = '{4'b0000, 10'h045, 32'h0,         7, 32'hA000_0045};
        vecs[5] = '{4'b0000, 10'h005, 32'h0,         7, 32'hA000_0005};
        vecs[6] = '{4'b1111, 10'h100, 32'hDEAD_BEEF, 1, 32'h0};
        vecs[7] = '{4'b0000, 10'h100, 32'h0,         7, 32'hDEAD_BEEF};

        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 4'b0000;
        cpu_addr  = '0;
        cpu_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_outputs_zero("post-reset");

        for (int i = 0; i < 8; i++) begin
            model_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rd);
            run_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    vecs[i].lat, vecs[i].rdata);
        end

        // Reset in the middle of a refill: abort, clear everything, no line left valid.
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 4'b0000;
        cpu_addr = 10'h200;
        repeat (4) @(posedge clk);
        #1;
        chk("refill2 mem_en",   32'(mem_en),   32'h1);
        chk("refill2 mem_addr", 32'(mem_addr), 32'h202);
        rst = 1'b1;
        #1;
        check_outputs_zero("async reset");
        cpu_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
        @(posedge clk);
        #1;
        check_outputs_zero("after abort");

        model_access(4'b0000, 10'h200, 32'h0, lat, rd);
        run_txn("reload 200", 4'b0000, 10'h200, 32'h0, lat, rd);
        model_access(4'b0000, 10'h005, 32'h0, lat, rd);
        run_txn("reload 005", 4'b0000, 10'h005, 32'h0, lat, rd);
        model_access(4'b0000, 10'h203, 32'h0, lat, rd);
        run_txn("hit 203", 4'b0000, 10'h203, 32'h0, lat, rd);

        for (int i = 0; i < 300; i++) begin
            a  = AW'($urandom_range(0, 255));
            wd = $urandom;
            we = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            model_access(we, a, wd, lat, rd);
            run_txn($sformatf("rnd%0d", i), we, a, wd, lat, rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
